// File: rtl/ram_dual_port_if.sv
// Signal bundle for the two ports of ram_dual_port.
// The master drives addresses, write data and write enables; the slave returns the registered read data.
interface ram_dual_port_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
);
    logic [DATA_WIDTH-1:0] data1;
    logic [ADDR_WIDTH-1:0] adr1;
    logic                  we1;
    logic [DATA_WIDTH-1:0] q1;
    logic [DATA_WIDTH-1:0] data2;
    logic [ADDR_WIDTH-1:0] adr2;
    logic                  we2;
    logic [DATA_WIDTH-1:0] q2;

    modport master (
        output data1, adr1, we1, data2, adr2, we2,
        input  q1, q2
    );

    modport slave (
        input  data1, adr1, we1, data2, adr2, we2,
        output q1, q2
    );
endinterface

// File: rtl/ram_dual_port.sv
// True dual-port synchronous RAM with registered read data on both ports.
// Reads return the old contents on a same-address collision, and port 1 wins a double write.
module ram_dual_port #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic            clk,
    input  logic            rst,
    ram_dual_port_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] q1_q, q1_d;
    logic [DATA_WIDTH-1:0] q2_q, q2_d;

    // Storage is never reset. Port 2 is written first so that port 1's later
    // assignment to the same address takes effect.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (bus.we2) mem[bus.adr2] <= bus.data2;
            if (bus.we1) mem[bus.adr1] <= bus.data1;
        end
    end

    always_comb begin
        q1_d = q1_q;
        q2_d = q2_q;
        if (!bus.we1) q1_d = mem[bus.adr1];
        if (!bus.we2) q2_d = mem[bus.adr2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1_q <= '0;
            q2_q <= '0;
        end else begin
            q1_q <= q1_d;
            q2_q <= q2_d;
        end
    end

    assign bus.q1 = q1_q;
    assign bus.q2 = q2_q;
endmodule

// File: tb/tb_ram_dual_port.sv
// Directed test for ram_dual_port: a behavioural memory model checked on every falling edge,
// plus literal expectations taken from hand-worked cycles.
module tb_ram_dual_port;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    ram_dual_port_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) bus ();

    ram_dual_port #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: a plain array of words plus "known" flags so unwritten locations are never compared.
    logic [7:0] modelMem   [64];
    bit         modelKnown [64];
    logic [7:0] expQ1, expQ2;
    bit         expKnown1 = 1'b0;
    bit         expKnown2 = 1'b0;

    initial begin
        for (int i = 0; i < 64; i++) modelKnown[i] = 1'b0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            expQ1 = 8'h00; expKnown1 = 1'b1;
            expQ2 = 8'h00; expKnown2 = 1'b1;
        end else begin
            if (!bus.we1) begin expQ1 = modelMem[bus.adr1]; expKnown1 = modelKnown[bus.adr1]; end
            if (!bus.we2) begin expQ2 = modelMem[bus.adr2]; expKnown2 = modelKnown[bus.adr2]; end
            if (bus.we2) begin modelMem[bus.adr2] = bus.data2; modelKnown[bus.adr2] = 1'b1; end
            if (bus.we1) begin modelMem[bus.adr1] = bus.data1; modelKnown[bus.adr1] = 1'b1; end
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (expKnown1) checkOutput("model_q1", bus.q1, expQ1);
        if (expKnown2) checkOutput("model_q2", bus.q2, expQ2);
    end

    // Drives one cycle's inputs, then returns 1 time unit after the rising edge that consumes them.
    task automatic applyStimulus(input logic w1, input logic [5:0] a1, input logic [7:0] d1,
                                 input logic w2, input logic [5:0] a2, input logic [7:0] d2);
        bus.we1 = w1; bus.adr1 = a1; bus.data1 = d1;
        bus.we2 = w2; bus.adr2 = a2; bus.data2 = d2;
        @(posedge clk);
        #1;
    endtask

    task automatic expectBoth(input string name, input logic [7:0] e1, input logic [7:0] e2);
        checkOutput({name, "_q1"}, bus.q1, e1);
        checkOutput({name, "_q2"}, bus.q2, e2);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.we1 = 1'b0; bus.adr1 = '0; bus.data1 = '0;
        bus.we2 = 1'b0; bus.adr2 = '0; bus.data2 = '0;
        repeat (2) @(posedge clk);
        #1;
        expectBoth("reset", 8'h00, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(1'b1, 6'd1, 8'h33, 1'b1, 6'd2, 8'h44);
        expectBoth("dual_write_hold", 8'h00, 8'h00);
        applyStimulus(1'b1, 6'd3, 8'h55, 1'b0, 6'd1, 8'h00);
        expectBoth("write_and_read", 8'h00, 8'h33);
        applyStimulus(1'b0, 6'd2, 8'h00, 1'b0, 6'd3, 8'h00);
        expectBoth("cross_read", 8'h44, 8'h55);
        applyStimulus(1'b0, 6'd1, 8'h00, 1'b0, 6'd1, 8'h00);
        expectBoth("both_read_same", 8'h33, 8'h33);

        // Mid-cycle reset pulse: outputs clear at once, and writes attempted under reset are dropped.
        #2;
        rst = 1'b1;
        #1;
        expectBoth("async_reset", 8'h00, 8'h00);
        bus.we1 = 1'b1; bus.adr1 = 6'd1; bus.data1 = 8'h99;
        bus.we2 = 1'b1; bus.adr2 = 6'd3; bus.data2 = 8'h98;
        @(posedge clk);
        #1;
        expectBoth("reset_held", 8'h00, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(1'b0, 6'd1, 8'h00, 1'b1, 6'd2, 8'h77);
        expectBoth("retained_and_hold", 8'h33, 8'h00);
        applyStimulus(1'b0, 6'd2, 8'h00, 1'b0, 6'd3, 8'h00);
        expectBoth("read_new_and_blocked", 8'h77, 8'h55);

        applyStimulus(1'b1, 6'd5, 8'hAA, 1'b1, 6'd5, 8'hBB);
        expectBoth("write_collision_hold", 8'h77, 8'h55);
        applyStimulus(1'b0, 6'd5, 8'h00, 1'b0, 6'd5, 8'h00);
        expectBoth("port1_wins", 8'hAA, 8'hAA);

        applyStimulus(1'b1, 6'd6, 8'h11, 1'b0, 6'd5, 8'h00);
        expectBoth("preload_6", 8'hAA, 8'hAA);
        applyStimulus(1'b1, 6'd6, 8'h22, 1'b0, 6'd6, 8'h00);
        expectBoth("rd_before_wr_p2", 8'hAA, 8'h11);
        applyStimulus(1'b0, 6'd6, 8'h00, 1'b0, 6'd6, 8'h00);
        expectBoth("after_collision", 8'h22, 8'h22);

        applyStimulus(1'b0, 6'd5, 8'h00, 1'b1, 6'd5, 8'hCC);
        expectBoth("rd_before_wr_p1", 8'hAA, 8'h22);
        applyStimulus(1'b0, 6'd5, 8'h00, 1'b0, 6'd5, 8'h00);
        expectBoth("p2_write_visible", 8'hCC, 8'hCC);

        applyStimulus(1'b1, 6'd0, 8'hFF, 1'b1, 6'd63, 8'h5A);
        expectBoth("boundary_write_hold", 8'hCC, 8'hCC);
        applyStimulus(1'b0, 6'd0, 8'h00, 1'b0, 6'd63, 8'h00);
        expectBoth("boundary_read", 8'hFF, 8'h5A);
        applyStimulus(1'b0, 6'd63, 8'h00, 1'b0, 6'd0, 8'h00);
        expectBoth("boundary_swap", 8'h5A, 8'hFF);
        applyStimulus(1'b0, 6'd1, 8'h00, 1'b0, 6'd2, 8'h00);
        expectBoth("no_aliasing", 8'h33, 8'h77);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
